// File: rtl/input_pkg.sv
// Shared constants for the player-input front end.
package input_pkg;

  localparam int unsigned NUM_BUTTONS  = 5;
  localparam int unsigned EVENT_CODE_W = 3;
  localparam int unsigned STABLE_CNT_W = 4;
  localparam int unsigned HOLD_CNT_W   = 8;

  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_ACTION = 4;

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-FF synchroniser, frame-rate debounce, press detect and
// auto-repeat. press/rpt are single-cycle strobes coincident with the sample
// edge so the pending flag sets on the same edge that buttons_db rises.
module button_debouncer
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned REPEAT_FRAMES   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic sample,
  output logic btn_db,
  output logic press,
  output logic rpt
);

  logic                    sync_q1;
  logic                    sync_q2;
  logic [STABLE_CNT_W-1:0] stable_cnt;
  logic [HOLD_CNT_W-1:0]   hold_cnt;
  logic                    flip_c;
  logic                    held_c;

  // Flip, press and repeat decode for the current sample edge.
  always_comb begin
    flip_c = sample && (sync_q2 != btn_db) &&
             ((stable_cnt + STABLE_CNT_W'(1)) == STABLE_CNT_W'(DEBOUNCE_FRAMES));
    press  = flip_c && sync_q2;
    // A button that is releasing on this edge no longer counts as held.
    held_c = btn_db && !flip_c;
    rpt    = (REPEAT_FRAMES != 0) && sample && held_c &&
             ((hold_cnt + HOLD_CNT_W'(1)) == HOLD_CNT_W'(REPEAT_FRAMES));
  end

  // Pad synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Stable counter and debounced level, advanced only on sample edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_cnt <= '0;
      btn_db     <= 1'b0;
    end else if (sample) begin
      if (sync_q2 == btn_db) begin
        stable_cnt <= '0;
      end else if (flip_c) begin
        btn_db     <= sync_q2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + STABLE_CNT_W'(1);
      end
    end
  end

  // Hold counter; parked at zero when repeat is disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
    end else if (sample) begin
      if (!held_c || rpt || (REPEAT_FRAMES == 0)) begin
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_controller.sv
// Frame-synchronous input front end: per-button debounce, sticky pending
// flags, fixed-priority select and a single valid/ready event register.
module input_controller #(
  parameter int unsigned NUM_BUTTONS     = input_pkg::NUM_BUTTONS,
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned REPEAT_FRAMES   = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_BUTTONS-1:0]               buttons_raw,
  input  logic                                 frame_end,
  input  logic                                 input_enable,
  input  logic                                 event_ready,
  output logic                                 event_valid,
  output logic [input_pkg::EVENT_CODE_W-1:0]   event_code,
  output logic [NUM_BUTTONS-1:0]               buttons_db,
  output logic                                 frame_tick
);

  import input_pkg::*;

  logic                    sample_c;
  logic [NUM_BUTTONS-1:0]  press_v;
  logic [NUM_BUTTONS-1:0]  rpt_v;
  logic [NUM_BUTTONS-1:0]  pending;
  logic [NUM_BUTTONS-1:0]  pending_nxt;
  logic [NUM_BUTTONS-1:0]  sel_onehot;
  logic [EVENT_CODE_W-1:0] sel_idx;
  logic                    sel_found;
  logic                    load_c;

  assign sample_c = frame_end && input_enable;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
      .REPEAT_FRAMES   (REPEAT_FRAMES)
    ) u_btn (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (buttons_raw[g]),
      .sample  (sample_c),
      .btn_db  (buttons_db[g]),
      .press   (press_v[g]),
      .rpt     (rpt_v[g])
    );
  end

  // Lowest-index pending flag wins; new sets this edge are not eligible yet.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (pending[i] && !sel_found) begin
        sel_found     = 1'b1;
        sel_idx       = EVENT_CODE_W'(i);
        sel_onehot[i] = 1'b1;
      end
    end
    load_c      = !event_valid || event_ready;
    // Set beats clear when both hit the same flag.
    pending_nxt = (pending & ~(load_c ? sel_onehot : '0)) | press_v | rpt_v;
  end

  // Pending flags, output register and frame step pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending     <= '0;
      event_valid <= 1'b0;
      event_code  <= '0;
      frame_tick  <= 1'b0;
    end else begin
      pending    <= pending_nxt;
      frame_tick <= sample_c;
      if (load_c) begin
        event_valid <= sel_found;
        if (sel_found) begin
          event_code <= sel_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_input_controller.sv
// Directed bench for input_controller (debounce 2, repeat 16) with a second
// instance that has repeat disabled.
module tb_input_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] buttons_raw = '0;
  logic       frame_end = 1'b0;
  logic       input_enable = 1'b1;
  logic       event_ready = 1'b0;

  logic       event_valid, event_valid0;
  logic [2:0] event_code, event_code0;
  logic [4:0] buttons_db, buttons_db0;
  logic       frame_tick, frame_tick0;

  int n_cmp = 0;
  int n_err = 0;
  int acc = 0;
  int acc0 = 0;
  logic [2:0] last_code = '0;

  always #5 clk = ~clk;

  input_controller #(.NUM_BUTTONS(5), .DEBOUNCE_FRAMES(2), .REPEAT_FRAMES(16)) dut (
    .clk(clk), .reset(reset), .buttons_raw(buttons_raw), .frame_end(frame_end),
    .input_enable(input_enable), .event_ready(event_ready), .event_valid(event_valid),
    .event_code(event_code), .buttons_db(buttons_db), .frame_tick(frame_tick));

  input_controller #(.NUM_BUTTONS(5), .DEBOUNCE_FRAMES(2), .REPEAT_FRAMES(0)) dut0 (
    .clk(clk), .reset(reset), .buttons_raw(buttons_raw), .frame_end(frame_end),
    .input_enable(input_enable), .event_ready(event_ready), .event_valid(event_valid0),
    .event_code(event_code0), .buttons_db(buttons_db0), .frame_tick(frame_tick0));

  // Accepted-event tallies.
  always @(posedge clk) begin
    if (event_valid && event_ready) begin
      acc       <= acc + 1;
      last_code <= event_code;
    end
    if (event_valid0 && event_ready) acc0 <= acc0 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two settle clocks, one frame_end edge, two idle clocks.
  task automatic frame(input logic en, output logic ft, output logic vs, output logic [4:0] dbs);
    tick();
    tick();
    frame_end    = 1'b1;
    input_enable = en;
    tick();
    frame_end    = 1'b0;
    input_enable = 1'b1;
    ft  = frame_tick;
    vs  = event_valid;
    dbs = buttons_db;
    tick();
    tick();
  endtask

  logic       ft, vs;
  logic [4:0] dbs;
  int         a, a0;

  initial begin
    // Reset held with all buttons pressed and frames running.
    buttons_raw = 5'b11111;
    frame(1'b1, ft, vs, dbs);
    check("rst_tick", 32'(ft), 32'd0);
    frame(1'b1, ft, vs, dbs);
    check("rst_valid", 32'(event_valid), 32'd0);
    check("rst_code", 32'(event_code), 32'd0);
    check("rst_db", 32'(buttons_db), 32'd0);
    reset = 1'b1;
    frame(1'b1, ft, vs, dbs);
    check("rel_f1_tick", 32'(ft), 32'd1);
    check("rel_f1_db", 32'(dbs), 32'd0);
    check("rel_f1_valid", 32'(event_valid), 32'd0);
    frame(1'b1, ft, vs, dbs);
    check("rel_f2_db", 32'(dbs), 32'h1f);
    check("rel_f2_vs", 32'(vs), 32'd0);
    check("rel_f2_valid", 32'(event_valid), 32'd1);
    check("rel_f2_code", 32'(event_code), 32'd0);
    a = acc;
    event_ready = 1'b1;
    buttons_raw = '0;
    frame(1'b1, ft, vs, dbs);
    frame(1'b1, ft, vs, dbs);
    event_ready = 1'b0;
    check("drain_count", 32'(acc - a), 32'd5);
    check("drain_valid", 32'(event_valid), 32'd0);
    check("drain_db", 32'(buttons_db), 32'd0);

    // Debounce reject then accept on button 0.
    buttons_raw = 5'b00001;
    frame(1'b1, ft, vs, dbs);
    buttons_raw = '0;
    frame(1'b1, ft, vs, dbs);
    frame(1'b1, ft, vs, dbs);
    check("rej_db", 32'(buttons_db), 32'd0);
    check("rej_valid", 32'(event_valid), 32'd0);
    buttons_raw = 5'b00001;
    frame(1'b1, ft, vs, dbs);
    check("acc_f1_db", 32'(dbs), 32'd0);
    frame(1'b1, ft, vs, dbs);
    check("acc_f2_db", 32'(dbs), 32'd1);
    check("acc_f2_vs", 32'(vs), 32'd0);
    check("acc_valid", 32'(event_valid), 32'd1);
    check("acc_code", 32'(event_code), 32'd0);
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
    check("acc_done", 32'(event_valid), 32'd0);
    buttons_raw = '0;
    frame(1'b1, ft, vs, dbs);
    frame(1'b1, ft, vs, dbs);
    check("acc_rel_db", 32'(buttons_db), 32'd0);
    check("acc_rel_valid", 32'(event_valid), 32'd0);

    // Priority: up and action together.
    buttons_raw = 5'b10001;
    frame(1'b1, ft, vs, dbs);
    frame(1'b1, ft, vs, dbs);
    tick();
    tick();
    check("pri_valid", 32'(event_valid), 32'd1);
    check("pri_code0", 32'(event_code), 32'd0);
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
    check("pri_valid2", 32'(event_valid), 32'd1);
    check("pri_code4", 32'(event_code), 32'd4);
    tick();
    check("pri_hold4", 32'(event_code), 32'd4);
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
    check("pri_empty", 32'(event_valid), 32'd0);
    buttons_raw = '0;
    frame(1'b1, ft, vs, dbs);
    frame(1'b1, ft, vs, dbs);

    // Auto-repeat on right: press plus repeats at 16 and 32 frames later.
    a  = acc;
    a0 = acc0;
    event_ready = 1'b1;
    buttons_raw = 5'b01000;
    for (int f = 0; f < 34; f++) frame(1'b1, ft, vs, dbs);
    buttons_raw = '0;
    frame(1'b1, ft, vs, dbs);
    frame(1'b1, ft, vs, dbs);
    event_ready = 1'b0;
    check("rep_count", 32'(acc - a), 32'd3);
    check("rep_code", 32'(last_code), 32'd3);
    check("rep_off_count", 32'(acc0 - a0), 32'd1);
    check("rep_off_valid", 32'(event_valid0), 32'd0);

    // Gated frame delays the flip by one sample edge.
    buttons_raw = 5'b00010;
    frame(1'b0, ft, vs, dbs);
    check("gate_tick", 32'(ft), 32'd0);
    check("gate_db0", 32'(dbs), 32'd0);
    frame(1'b1, ft, vs, dbs);
    check("gate_tick1", 32'(ft), 32'd1);
    check("gate_db1", 32'(dbs), 32'd0);
    frame(1'b1, ft, vs, dbs);
    check("gate_db2", 32'(dbs), 32'b00010);
    check("gate_code", 32'(event_code), 32'd1);
    check("gate_valid", 32'(event_valid), 32'd1);
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
    buttons_raw = '0;
    frame(1'b1, ft, vs, dbs);
    frame(1'b1, ft, vs, dbs);

    // Reset mid-handshake with left still pending.
    buttons_raw = 5'b00101;
    frame(1'b1, ft, vs, dbs);
    frame(1'b1, ft, vs, dbs);
    check("mr_valid", 32'(event_valid), 32'd1);
    check("mr_code", 32'(event_code), 32'd0);
    reset = 1'b0;
    #1;
    check("mr_async", 32'(event_valid), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    check("mr_no_event", 32'(event_valid), 32'd0);
    check("mr_db", 32'(buttons_db), 32'd0);
    frame(1'b1, ft, vs, dbs);
    check("mr_f1_valid", 32'(event_valid), 32'd0);
    frame(1'b1, ft, vs, dbs);
    check("mr_f2_valid", 32'(event_valid), 32'd1);
    check("mr_f2_code", 32'(event_code), 32'd0);
    a = acc;
    event_ready = 1'b1;
    buttons_raw = '0;
    frame(1'b1, ft, vs, dbs);
    frame(1'b1, ft, vs, dbs);
    event_ready = 1'b0;
    check("mr_drain", 32'(acc - a), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
